// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- multi-port register file with per-register pending scoreboard
//
// Purpose:
//   Register file for the pipelined MIPS core. Decode reads two operands
//   combinationally and marks the destination of each issued instruction as
//   pending. The two writeback paths (ALU/WB on port A, load return on
//   port B) write results and clear the pending bit of the written register.
//   Decode uses busy1/busy2 to detect RAW hazards.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   raddr1/raddr2       read indices
//   rdata1/rdata2       read data (combinational)
//   busy1/busy2         pending bit of the read index (combinational)
//   we_a/waddr_a/wdata_a  write port A
//   we_b/waddr_b/wdata_b  write port B (wins over A on the same index)
//   issue_en/issue_addr   mark a register pending at the next edge
//   pending_cnt         registered count of pending registers (0..NREG)
//
// Interface semantics:
//   There is no valid/ready handshake. Every enable (we_a, we_b, issue_en)
//   is a single-cycle command sampled on the rising edge of clk; the block
//   never back-pressures, so every command presented is accepted.
//
// Optional build:
//   REGFILE_BYPASS_EN  when defined, a write presented in the current cycle
//                      is forwarded to a matching read port (port B first),
//                      and the forwarded read reports not-busy unless the
//                      same register is also being issued this cycle.
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy1,
  output logic              busy2,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] waddr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] waddr_b,
  input  logic [DATA_W-1:0] wdata_b,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pending_q;
  logic [NREG-1:0]   pending_d;
  logic [ADDR_W:0]   cnt_d;
  logic [ADDR_W:0]   cnt_q;

  // True for the hard-wired zero register when that option is enabled.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard next state. Issue has priority over a write to the same
  // register: the instruction issued this cycle is the newer producer, so the
  // register must stay pending until that instruction writes back.
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    for (int r = 0; r < NREG; r++) begin
      if (issue_en && (issue_addr == ADDR_W'(r))) begin
        pending_d[r] = 1'b1;
      end else if ((we_a && (waddr_a == ADDR_W'(r))) ||
                   (we_b && (waddr_b == ADDR_W'(r)))) begin
        pending_d[r] = 1'b0;
      end
      if (is_zero(ADDR_W'(r))) begin
        pending_d[r] = 1'b0;
      end
    end
  end

  // Population count of the next pending vector, so the registered count
  // changes on the same edge as the bits it counts.
  always_comb begin
    cnt_d = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, pending_d[r]};
    end
  end

  // ---------------------------------------------------------------------------
  // State: register array, pending bits, pending count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (!is_zero(ADDR_W'(r))) begin
          // Port B is checked first: it wins when both ports hit one index.
          if (we_b && (waddr_b == ADDR_W'(r))) begin
            regs[r] <= wdata_b;
          end else if (we_a && (waddr_a == ADDR_W'(r))) begin
            regs[r] <= wdata_a;
          end
        end
      end
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending_cnt = cnt_q;

  // ---------------------------------------------------------------------------
  // Read path. Returns {busy, data} for one read index.
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] d;
    logic              b;
    d = regs[ra];
    b = pending_q[ra];
`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed during reset so reads show the cleared state.
    if (!rst) begin
      if (we_b && (waddr_b == ra)) begin
        d = wdata_b;
        if (!(issue_en && (issue_addr == ra))) b = 1'b0;
      end else if (we_a && (waddr_a == ra)) begin
        d = wdata_a;
        if (!(issue_en && (issue_addr == ra))) b = 1'b0;
      end
    end
`endif
    if (is_zero(ra)) begin
      d = '0;
      b = 1'b0;
    end
    return {b, d};
  endfunction

  always_comb begin
    {busy1, rdata1} = read_port(raddr1);
    {busy2, rdata2} = read_port(raddr2);
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  // Expected entry: {step[7:0], rdata1, rdata2, busy1, busy2, pending_cnt}
  localparam int W = 8 + DATA_W + DATA_W + 1 + 1 + (ADDR_W + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] raddr1, raddr2;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic              busy1, busy2;
  logic              we_a, we_b;
  logic [ADDR_W-1:0] waddr_a, waddr_b;
  logic [DATA_W-1:0] wdata_a, wdata_b;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W:0]   pending_cnt;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int step_no = 0;

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .busy1(busy1), .busy2(busy2),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .pending_cnt(pending_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic wa, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] da,
                       input logic wb, input logic [ADDR_W-1:0] ab, input logic [DATA_W-1:0] db,
                       input logic ie, input logic [ADDR_W-1:0] ia,
                       input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    we_a = wa; waddr_a = aa; wdata_a = da;
    we_b = wb; waddr_b = ab; wdata_b = db;
    issue_en = ie; issue_addr = ia;
    raddr1 = r1; raddr2 = r2;
  endtask

  // Push the outputs expected in the current cycle, then advance one cycle.
  task automatic expect_step(input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2,
                             input logic eb1, input logic eb2, input logic [ADDR_W:0] ec);
    step_no++;
    exp_q.push_back({8'(step_no), e1, e2, eb1, eb2, ec});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic cmp(input string name, input int stp, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL step %0d %s: got %h expected %h", stp, name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      int stp;
      e = exp_q.pop_front();
      stp = int'(e[W-1 -: 8]);
      cmp("rdata1", stp, rdata1, e[W-9 -: DATA_W]);
      cmp("rdata2", stp, rdata2, e[W-9-DATA_W -: DATA_W]);
      cmp("busy1",  stp, {{(DATA_W-1){1'b0}}, busy1}, {{(DATA_W-1){1'b0}}, e[ADDR_W+2]});
      cmp("busy2",  stp, {{(DATA_W-1){1'b0}}, busy2}, {{(DATA_W-1){1'b0}}, e[ADDR_W+1]});
      cmp("pending_cnt", stp, {{(DATA_W-ADDR_W-1){1'b0}}, pending_cnt},
          {{(DATA_W-ADDR_W-1){1'b0}}, e[ADDR_W:0]});
    end
  end

  // ---------------- stimulus ----------------
`ifdef REGFILE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  initial begin
    rst = 1'b1;
    idle(0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    idle(0, 31);                                   expect_step(0, 0, 0, 0, 0);
    // Load reg5, then read it back
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 2); expect_step(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 6, 5, 5);           expect_step(32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
    idle(5, 6);                                    expect_step(32'hDEADBEEF, 0, 0, 1, 1);
    // Async reset mid-cycle with a write in flight: outputs clear before any edge
    rst = 1'b1;
    drive(1, 5, 32'h77, 0, 0, 0, 0, 0, 5, 6);      expect_step(0, 0, 0, 0, 0);
    rst = 1'b0;
    idle(5, 6);                                    expect_step(0, 0, 0, 0, 0);
    // Both ports write reg3: B wins
    drive(1, 3, 32'h11, 1, 3, 32'h22, 0, 0, 1, 2); expect_step(0, 0, 0, 0, 0);
    idle(3, 3);                                    expect_step(32'h22, 32'h22, 0, 0, 0);
    // Register 0: write and issue are both ignored
    drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0); expect_step(0, 0, 0, 0, 0);
    idle(0, 0);                                    expect_step(0, 0, 0, 0, 0);
    // Issue reg7, later written by port A
    drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);           expect_step(0, 0, 0, 0, 0);
    idle(7, 0);                                    expect_step(0, 0, 1, 0, 1);
    drive(1, 7, 32'h55, 0, 0, 0, 0, 0, 7, 0);
    expect_step(BYP ? 32'h55 : 32'h0, 0, BYP ? 1'b0 : 1'b1, 0, 1);
    idle(7, 0);                                    expect_step(32'h55, 0, 0, 0, 0);
    // Issue and write reg9 on the same edge: data lands, stays pending
    drive(0, 0, 0, 1, 9, 32'hAB, 1, 9, 9, 0);
    expect_step(BYP ? 32'hAB : 32'h0, 0, 0, 0, 0);
    idle(9, 0);                                    expect_step(32'hAB, 0, 1, 0, 1);
    // Re-issue an already pending register
    drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);           expect_step(32'hAB, 0, 1, 0, 1);
    idle(9, 0);                                    expect_step(32'hAB, 0, 1, 0, 1);
    // Clear reg9 through port A while issuing reg10
    drive(1, 9, 32'h99, 0, 0, 0, 1, 10, 9, 10);
    expect_step(BYP ? 32'h99 : 32'hAB, 0, BYP ? 1'b0 : 1'b1, 0, 1);
    idle(9, 10);                                   expect_step(32'h99, 0, 0, 1, 1);
    // Same-cycle forwarding of port A to read port 2
    drive(1, 4, 32'h1234, 0, 0, 0, 0, 0, 10, 4);
    expect_step(0, BYP ? 32'h1234 : 32'h0, 1, 0, 1);
    idle(10, 4);                                   expect_step(0, 32'h1234, 1, 0, 1);
    // Port B write clears reg10
    drive(0, 0, 0, 1, 10, 32'h5A, 0, 0, 10, 4);
    expect_step(BYP ? 32'h5A : 32'h0, 32'h1234, BYP ? 1'b0 : 1'b1, 0, 1);
    idle(10, 4);                                   expect_step(32'h5A, 32'h1234, 0, 0, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined MIPS core; successor to the single-write-port register file.
- Provides 2 combinational read ports, 2 synchronous write ports (ALU/WB and load/MEM return), async clear, and a per-register pending scoreboard.
- Decode uses the scoreboard to detect RAW hazards.
- Sits between the decode stage (reads, issue) and the writeback stages (writes).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth NREG = 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never pending.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset: asynchronous, active-high.
- raddr1  in  ADDR_W  read port 1 index.
- raddr2  in  ADDR_W  read port 2 index.
- rdata1  out  DATA_W  read port 1 data, combinational.
- rdata2  out  DATA_W  read port 2 data, combinational.
- busy1  out  1  pending bit of raddr1, combinational.
- busy2  out  1  pending bit of raddr2, combinational.
- we_a  in  1  write enable, port A.
- waddr_a  in  ADDR_W  write index, port A.
- wdata_a  in  DATA_W  write data, port A.
- we_b  in  1  write enable, port B.
- waddr_b  in  ADDR_W  write index, port B.
- wdata_b  in  DATA_W  write data, port B.
- issue_en  in  1  mark a register pending (instruction issued with this destination).
- issue_addr  in  ADDR_W  register to mark pending.
- pending_cnt  out  ADDR_W+1  number of registers currently pending (registered).

Behaviour:
- Reset (rst=1, any time, async): all NREG registers clear to 0, all pending bits clear to 0, pending_cnt=0.
  - rdata*/busy* follow immediately: 0 for all addresses.
  - Reset mid-write: that write is lost.
- Writes: on rising clk, if we_a then reg[waddr_a]<=wdata_a; if we_b then reg[waddr_b]<=wdata_b.
  - Both enabled, same index: port B wins.
  - Write latency: 1 cycle; value visible on rdata from the edge onward.
- Reads: rdata = reg[raddr] combinationally.
  - With ZERO_REG=1 and raddr=0, rdata=0 regardless of array content.
  - Without bypass (see feature): a same-cycle write is not visible until after the edge.
- Scoreboard, per register r, at rising clk:
  - Set if issue_en && issue_addr==r.
  - Else cleared if (we_a && waddr_a==r) || (we_b && waddr_b==r).
  - Else held.
  - Issue and write to the same register in one cycle: stays/becomes pending; the newer producer wins.
  - Issue to an already-pending register: stays pending; no error.
  - ZERO_REG=1: register 0 never becomes pending; issue to 0 is ignored.
- busy1/busy2 = pending[raddr] combinationally.
- pending_cnt: registered population count of the pending bits; updated the same edge as the bits; range 0..NREG.
- Write to a non-pending register: data updates; pending unchanged (stays 0).

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - Write-through forwarding: if we_b && waddr_b==raddr, rdata=wdata_b; else if we_a && waddr_a==raddr, rdata=wdata_a; else array.
  - busy for that raddr reads 0 in the same cycle, unless issue_en && issue_addr==raddr.
  - The ZERO_REG override still applies; raddr 0 never forwards.
- Undefined: reads return array contents only; busy reflects registered pending bits only.

Test Plan:
- Assert rst after writing reg5=0xDEADBEEF, raddr1=5 -> rdata1=0 immediately, before any clk edge; pending_cnt=0.
- we_a=1 waddr_a=3 wdata_a=0x11, we_b=1 waddr_b=3 wdata_b=0x22 -> after the edge rdata1(raddr1=3)=0x22.
- Write reg0 with 0xFFFFFFFF, and issue_en to reg0 (ZERO_REG=1) -> rdata=0, busy=0, pending_cnt=0.
- issue_en reg7 at cycle 0 -> busy1(raddr1=7)=1 and pending_cnt=1 from cycle 1. we_a reg7=0x55 at cycle 2 -> from cycle 3: busy1=0, rdata1=0x55, pending_cnt=0.
- Same edge: issue_en reg9 and we_b reg9=0xAB -> reg9=0xAB and busy=1 after the edge; pending_cnt increments by 1.
- Bypass: we_a reg4=0x1234, raddr2=4 in the same cycle -> rdata2=0x1234 before the edge with REGFILE_BYPASS_EN defined; old value (0) without it.
